// File: rtl/rob_commit_ctrl_pkg.sv
// Shared ROB sizing constants, entry layout and tag/slot helpers.
// Tags are slot+1 so that tag 0 can mean "no producer".
package rob_commit_ctrl_pkg;

  localparam int unsigned ROB_SZ_LOG = 3;
  localparam int unsigned ROB_SZ     = 1 << ROB_SZ_LOG;
  localparam int unsigned REG_SZ_LOG = 5;
  localparam int unsigned TAG_W      = ROB_SZ_LOG + 1;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [ROB_SZ_LOG-1:0] slot_t;
  typedef logic [REG_SZ_LOG-1:0] reg_t;

  localparam tag_t TAG_NONE = '0;

  typedef struct packed {
    logic rd_hv;
    reg_t rd;
    logic is_br;
    logic pred_taken;
  } alloc_info_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    alloc_info_t info;
    logic        actual_taken;
    logic [31:0] value;
    logic [31:0] redirect_pc;
  } rob_entry_t;

  function automatic slot_t tag_to_slot(tag_t t);
    return slot_t'(t - tag_t'(1));
  endfunction

  function automatic tag_t slot_to_tag(slot_t s);
    return tag_t'({1'b0, s}) + tag_t'(1);
  endfunction

  // Tags above ROB_SZ would alias onto real slots after truncation.
  function automatic logic tag_in_range(tag_t t);
    return (t != TAG_NONE) && (t <= tag_t'(ROB_SZ));
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / writeback / lookup / commit signal bundle of the ROB controller.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic        rdy;
  logic        alloc_valid;
  logic        alloc_rd_hv;
  reg_t        alloc_rd;
  logic        alloc_is_br;
  logic        alloc_pred_taken;
  logic        alloc_ready;
  tag_t        alloc_tag;
  logic        wb_valid;
  tag_t        wb_tag;
  logic [31:0] wb_value;
  logic        wb_br_taken;
  logic [31:0] wb_redirect_pc;
  tag_t        q1_tag;
  tag_t        q2_tag;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;
  logic        run_upd;
  reg_t        commit_rd;
  logic [31:0] res;
  tag_t        head;
  logic        commit_wr;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output rdy, alloc_valid, alloc_rd_hv, alloc_rd, alloc_is_br, alloc_pred_taken,
           wb_valid, wb_tag, wb_value, wb_br_taken, wb_redirect_pc, q1_tag, q2_tag,
    input  alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           run_upd, commit_rd, res, head, commit_wr, flush, flush_pc
  );

  modport slave (
    input  rdy, alloc_valid, alloc_rd_hv, alloc_rd, alloc_is_br, alloc_pred_taken,
           wb_valid, wb_tag, wb_value, wb_br_taken, wb_redirect_pc, q1_tag, q2_tag,
    output alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           run_upd, commit_rd, res, head, commit_wr, flush, flush_pc
  );

endinterface

// File: rtl/rob_commit_ctrl_entry_array.sv
// ROB entry storage: one alloc write port, one writeback port, a head read
// port and two lookup read ports. All write enables arrive pre-qualified.
module rob_entry_array
  import rob_commit_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_we,
  input  slot_t       alloc_slot,
  input  alloc_info_t alloc_info,
  input  logic        wb_we,
  input  slot_t       wb_slot,
  input  logic [31:0] wb_value,
  input  logic        wb_taken,
  input  logic [31:0] wb_pc,
  input  logic        commit_clr,
  input  slot_t       head_slot,
  input  logic        clear_all,
  input  slot_t       q1_slot,
  input  slot_t       q2_slot,
  output rob_entry_t  head_entry,
  output rob_entry_t  q1_entry,
  output rob_entry_t  q2_entry
);

  rob_entry_t mem [ROB_SZ];

  // Commit invalidation is written last so it wins over a same-edge writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) mem[i] <= '0;
    end else if (clear_all) begin
      for (int unsigned i = 0; i < ROB_SZ; i++) mem[i].valid <= 1'b0;
    end else begin
      if (alloc_we) begin
        mem[alloc_slot].valid <= 1'b1;
        mem[alloc_slot].ready <= 1'b0;
        mem[alloc_slot].info  <= alloc_info;
      end
      if (wb_we && mem[wb_slot].valid) begin
        mem[wb_slot].ready        <= 1'b1;
        mem[wb_slot].value        <= wb_value;
        mem[wb_slot].actual_taken <= wb_taken;
        mem[wb_slot].redirect_pc  <= wb_pc;
      end
      if (commit_clr) mem[head_slot].valid <= 1'b0;
    end
  end

  assign head_entry = mem[head_slot];
  assign q1_entry   = mem[q1_slot];
  assign q2_entry   = mem[q2_slot];

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB controller: tag allocation, writeback capture, one commit per
// cycle, and whole-window flush on a mispredicted branch at commit.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  rob_commit_ctrl_if.slave  bus
);

  localparam tag_t FULL_CNT = tag_t'(ROB_SZ);

  slot_t       head_ptr;
  slot_t       tail_ptr;
  tag_t        count;
  logic        flush_q;
  logic [31:0] flush_pc_q;

  rob_entry_t  head_e;
  rob_entry_t  q1_e;
  rob_entry_t  q2_e;
  alloc_info_t alloc_info;

  logic alloc_ok;
  logic alloc_fire;
  logic wb_fire;
  logic commit;
  logic mispredict;

  always_comb begin
    alloc_ok   = (count != FULL_CNT) && !flush_q;
    alloc_fire = bus.rdy && bus.alloc_valid && alloc_ok;
    wb_fire    = bus.rdy && bus.wb_valid && !flush_q && tag_in_range(bus.wb_tag);
    commit     = bus.rdy && !flush_q && head_e.valid && head_e.ready;
    mispredict = commit && head_e.info.is_br &&
                 (head_e.info.pred_taken != head_e.actual_taken);
    alloc_info = '{rd_hv: bus.alloc_rd_hv, rd: bus.alloc_rd,
                   is_br: bus.alloc_is_br, pred_taken: bus.alloc_pred_taken};
  end

  // Same-edge alloc/writeback are dropped on mispredict via clear_all priority.
  rob_entry_array u_entries (
    .clk        (clk),
    .rst        (rst),
    .alloc_we   (alloc_fire),
    .alloc_slot (tail_ptr),
    .alloc_info (alloc_info),
    .wb_we      (wb_fire),
    .wb_slot    (tag_to_slot(bus.wb_tag)),
    .wb_value   (bus.wb_value),
    .wb_taken   (bus.wb_br_taken),
    .wb_pc      (bus.wb_redirect_pc),
    .commit_clr (commit),
    .head_slot  (head_ptr),
    .clear_all  (mispredict),
    .q1_slot    (tag_to_slot(bus.q1_tag)),
    .q2_slot    (tag_to_slot(bus.q2_tag)),
    .head_entry (head_e),
    .q1_entry   (q1_e),
    .q2_entry   (q2_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (bus.rdy) begin
      if (mispredict) begin
        head_ptr   <= '0;
        tail_ptr   <= '0;
        count      <= '0;
        flush_q    <= 1'b1;
        flush_pc_q <= head_e.redirect_pc;
      end else begin
        flush_q <= 1'b0;
        if (alloc_fire) tail_ptr <= tail_ptr + slot_t'(1);
        if (commit)     head_ptr <= head_ptr + slot_t'(1);
        case ({alloc_fire, commit})
          2'b10:   count <= count + tag_t'(1);
          2'b01:   count <= count - tag_t'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign bus.alloc_ready = alloc_ok;
  assign bus.alloc_tag   = slot_to_tag(tail_ptr);
  assign bus.run_upd     = commit;
  assign bus.commit_rd   = commit ? head_e.info.rd : '0;
  assign bus.res         = commit ? head_e.value : '0;
  assign bus.head        = slot_to_tag(head_ptr);
  assign bus.commit_wr   = commit && head_e.info.rd_hv;
  assign bus.flush       = flush_q;
  assign bus.flush_pc    = flush_pc_q;
  assign bus.q1_ready    = tag_in_range(bus.q1_tag) && q1_e.valid && q1_e.ready;
  assign bus.q2_ready    = tag_in_range(bus.q2_tag) && q2_e.valid && q2_e.ready;
  assign bus.q1_value    = bus.q1_ready ? q1_e.value : '0;
  assign bus.q2_value    = bus.q2_ready ? q2_e.value : '0;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios plus a
// randomized run against a queue-based in-order ROB model.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    tag_t        tag;
    logic        hv;
    reg_t        rd;
    logic        br;
    logic        pred;
    logic        done;
    logic [31:0] val;
    logic        tk;
    logic [31:0] pc;
  } ment_t;

  task automatic idle();
    bus.rdy = 1'b1;          bus.alloc_valid = 1'b0;  bus.alloc_rd_hv = 1'b0;
    bus.alloc_rd = '0;       bus.alloc_is_br = 1'b0;  bus.alloc_pred_taken = 1'b0;
    bus.wb_valid = 1'b0;     bus.wb_tag = '0;         bus.wb_value = '0;
    bus.wb_br_taken = 1'b0;  bus.wb_redirect_pc = '0; bus.q1_tag = '0; bus.q2_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_alloc(input logic hv, input reg_t rd, input logic br, input logic pred);
    bus.alloc_valid = 1'b1; bus.alloc_rd_hv = hv; bus.alloc_rd = rd;
    bus.alloc_is_br = br;   bus.alloc_pred_taken = pred;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input tag_t t, input logic [31:0] v, input logic tk, input logic [31:0] pc);
    bus.wb_valid = 1'b1; bus.wb_tag = t; bus.wb_value = v;
    bus.wb_br_taken = tk; bus.wb_redirect_pc = pc;
    step();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0h exp=1", bus.alloc_ready); end
    checks++; if (bus.alloc_tag !== 4'd1) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=1", bus.alloc_tag); end
    checks++; if (bus.head !== 4'd1) begin failures++; $display("FAIL reset_head got=%0d exp=1", bus.head); end
    checks++; if (bus.run_upd !== 1'b0) begin failures++; $display("FAIL reset_run_upd got=%0h exp=0", bus.run_upd); end
    checks++; if (bus.commit_wr !== 1'b0) begin failures++; $display("FAIL reset_commit_wr got=%0h exp=0", bus.commit_wr); end
    checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0h exp=0", bus.flush); end
    checks++; if (bus.flush_pc !== 32'd0) begin failures++; $display("FAIL reset_flush_pc got=%0h exp=0", bus.flush_pc); end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_in_order_commit();
    apply_reset();
    bus.alloc_valid = 1'b1; bus.alloc_rd_hv = 1'b1; bus.alloc_rd = 5'd5; #1;
    checks++; if (bus.alloc_tag !== 4'd1) begin failures++; $display("FAIL order_tag1 got=%0d exp=1", bus.alloc_tag); end
    do_alloc(1'b1, 5'd5, 1'b0, 1'b0);
    do_alloc(1'b1, 5'd6, 1'b0, 1'b0);
    #1;
    checks++; if (bus.alloc_tag !== 4'd3) begin failures++; $display("FAIL order_tag3 got=%0d exp=3", bus.alloc_tag); end
    do_alloc(1'b1, 5'd7, 1'b0, 1'b0);
    do_wb(4'd3, 32'd30, 1'b0, 32'd0);
    bus.q1_tag = 4'd3; #1;
    checks++; if (bus.run_upd !== 1'b0) begin failures++; $display("FAIL order_no_early_commit got=%0h exp=0", bus.run_upd); end
    checks++; if (bus.q1_ready !== 1'b1 || bus.q1_value !== 32'd30) begin failures++; $display("FAIL order_lookup3 got=%0h/%0d exp=1/30", bus.q1_ready, bus.q1_value); end
    do_wb(4'd1, 32'd10, 1'b0, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd2; bus.wb_value = 32'd20; bus.q2_tag = 4'd2; #1;
    checks++; if (bus.q2_ready !== 1'b0) begin failures++; $display("FAIL order_no_wb_forward got=%0h exp=0", bus.q2_ready); end
    checks++; if ({bus.run_upd, bus.head, bus.commit_rd, bus.commit_wr} !== {1'b1, 4'd1, 5'd5, 1'b1} || bus.res !== 32'd10)
      begin failures++; $display("FAIL order_commit1 got=%0h/%0d/%0d/%0d exp=1/1/5/10", bus.run_upd, bus.head, bus.commit_rd, bus.res); end
    step();
    bus.wb_valid = 1'b0; #1;
    checks++; if ({bus.run_upd, bus.head, bus.commit_rd} !== {1'b1, 4'd2, 5'd6} || bus.res !== 32'd20)
      begin failures++; $display("FAIL order_commit2 got=%0h/%0d/%0d/%0d exp=1/2/6/20", bus.run_upd, bus.head, bus.commit_rd, bus.res); end
    step();
    checks++; if ({bus.run_upd, bus.head, bus.commit_rd} !== {1'b1, 4'd3, 5'd7} || bus.res !== 32'd30)
      begin failures++; $display("FAIL order_commit3 got=%0h/%0d/%0d/%0d exp=1/3/7/30", bus.run_upd, bus.head, bus.commit_rd, bus.res); end
    step();
    checks++; if ({bus.run_upd, bus.head, bus.commit_rd} !== {1'b0, 4'd4, 5'd0} || bus.res !== 32'd0)
      begin failures++; $display("FAIL order_drained got=%0h/%0d/%0d/%0d exp=0/4/0/0", bus.run_upd, bus.head, bus.commit_rd, bus.res); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 8; i++) do_alloc(1'b1, reg_t'(i), 1'b0, 1'b0);
    #1;
    checks++; if (bus.alloc_ready !== 1'b0 || bus.alloc_tag !== 4'd1) begin failures++; $display("FAIL full_blocked got=%0h/%0d exp=0/1", bus.alloc_ready, bus.alloc_tag); end
    bus.alloc_valid = 1'b1; bus.alloc_rd_hv = 1'b1; bus.alloc_rd = 5'd20;
    do_wb(4'd1, 32'h77, 1'b0, 32'd0);
    checks++; if (bus.run_upd !== 1'b1 || bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_commit_no_credit got=%0h/%0h exp=1/0", bus.run_upd, bus.alloc_ready); end
    step();
    checks++; if ({bus.alloc_ready, bus.alloc_tag, bus.head} !== {1'b1, 4'd1, 4'd2}) begin failures++; $display("FAIL full_freed got=%0h/%0d/%0d exp=1/1/2", bus.alloc_ready, bus.alloc_tag, bus.head); end
    step();
    bus.alloc_valid = 1'b0; bus.q1_tag = 4'd1; #1;
    checks++; if ({bus.alloc_ready, bus.alloc_tag, bus.q1_ready} !== {1'b0, 4'd2, 1'b0}) begin failures++; $display("FAIL full_wrap_alloc got=%0h/%0d/%0h exp=0/2/0", bus.alloc_ready, bus.alloc_tag, bus.q1_ready); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    do_alloc(1'b1, 5'd1, 1'b0, 1'b0);
    do_alloc(1'b0, 5'd0, 1'b1, 1'b0);
    do_alloc(1'b1, 5'd3, 1'b0, 1'b0);
    do_alloc(1'b1, 5'd4, 1'b0, 1'b0);
    do_wb(4'd3, 32'd33, 1'b0, 32'd0);
    do_wb(4'd4, 32'd44, 1'b0, 32'd0);
    do_wb(4'd1, 32'd11, 1'b0, 32'd0);
    checks++; if (bus.run_upd !== 1'b1 || bus.head !== 4'd1) begin failures++; $display("FAIL mp_commit1 got=%0h/%0d exp=1/1", bus.run_upd, bus.head); end
    do_wb(4'd2, 32'd0, 1'b1, 32'h1000);
    bus.alloc_valid = 1'b1; bus.alloc_rd_hv = 1'b1; bus.alloc_rd = 5'd9; #1;
    checks++; if ({bus.run_upd, bus.head, bus.commit_wr, bus.flush} !== {1'b1, 4'd2, 1'b0, 1'b0}) begin failures++; $display("FAIL mp_commit_branch got=%0h/%0d/%0h/%0h exp=1/2/0/0", bus.run_upd, bus.head, bus.commit_wr, bus.flush); end
    step();
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd3; #1;
    checks++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h1000) begin failures++; $display("FAIL mp_flush got=%0h/%0h exp=1/1000", bus.flush, bus.flush_pc); end
    checks++; if ({bus.alloc_ready, bus.alloc_tag, bus.run_upd, bus.head} !== {1'b0, 4'd1, 1'b0, 4'd1}) begin failures++; $display("FAIL mp_flush_state got=%0h/%0d/%0h/%0d exp=0/1/0/1", bus.alloc_ready, bus.alloc_tag, bus.run_upd, bus.head); end
    step();
    bus.wb_valid = 1'b0; bus.q1_tag = 4'd3; #1;
    checks++; if ({bus.flush, bus.alloc_ready, bus.alloc_tag, bus.run_upd, bus.q1_ready} !== {1'b0, 1'b1, 4'd1, 1'b0, 1'b0}) begin failures++; $display("FAIL mp_after_flush got=%0h/%0h/%0d/%0h/%0h exp=0/1/1/0/0", bus.flush, bus.alloc_ready, bus.alloc_tag, bus.run_upd, bus.q1_ready); end
    step();
    bus.alloc_valid = 1'b0; #1;
    checks++; if ({bus.alloc_tag, bus.head, bus.run_upd} !== {4'd2, 4'd1, 1'b0}) begin failures++; $display("FAIL mp_first_alloc got=%0d/%0d/%0h exp=2/1/0", bus.alloc_tag, bus.head, bus.run_upd); end
  endtask

  task automatic test_bad_writeback();
    apply_reset();
    do_alloc(1'b1, 5'd1, 1'b0, 1'b0);
    do_alloc(1'b1, 5'd2, 1'b0, 1'b0);
    do_wb(4'd0, 32'd99, 1'b0, 32'd0);
    bus.q1_tag = 4'd1; #1;
    checks++; if (bus.run_upd !== 1'b0 || bus.q1_ready !== 1'b0) begin failures++; $display("FAIL badwb_tag0 got=%0h/%0h exp=0/0", bus.run_upd, bus.q1_ready); end
    do_wb(4'd5, 32'd98, 1'b0, 32'd0);
    bus.q1_tag = 4'd5; bus.q2_tag = 4'd0; #1;
    checks++; if ({bus.q1_ready, bus.q2_ready, bus.run_upd} !== 3'b000 || bus.q1_value !== 32'd0) begin failures++; $display("FAIL badwb_invalid got=%0h/%0h/%0h/%0h exp=0/0/0/0", bus.q1_ready, bus.q2_ready, bus.run_upd, bus.q1_value); end
    checks++; if (bus.alloc_tag !== 4'd3 || bus.head !== 4'd1) begin failures++; $display("FAIL badwb_state got=%0d/%0d exp=3/1", bus.alloc_tag, bus.head); end
  endtask

  task automatic test_rdy_hold();
    apply_reset();
    do_alloc(1'b1, 5'd5, 1'b0, 1'b0);
    do_wb(4'd1, 32'h55, 1'b0, 32'd0);
    bus.rdy = 1'b0; bus.alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.run_upd, bus.head, bus.alloc_tag} !== {1'b0, 4'd1, 4'd2}) begin failures++; $display("FAIL rdy_frozen got=%0h/%0d/%0d exp=0/1/2", bus.run_upd, bus.head, bus.alloc_tag); end
      step();
    end
    bus.rdy = 1'b1; bus.alloc_valid = 1'b0; #1;
    checks++; if (bus.run_upd !== 1'b1 || bus.res !== 32'h55) begin failures++; $display("FAIL rdy_resume got=%0h/%0h exp=1/55", bus.run_upd, bus.res); end
    step();
    checks++; if ({bus.run_upd, bus.head, bus.alloc_tag} !== {1'b0, 4'd2, 4'd2}) begin failures++; $display("FAIL rdy_after got=%0h/%0d/%0d exp=0/2/2", bus.run_upd, bus.head, bus.alloc_tag); end
  endtask

  task automatic fill_branch_head();
    do_alloc(1'b1, 5'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) do_alloc(1'b1, reg_t'(i), 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) do_wb(tag_t'(i), 32'(i), 1'b0, 32'd0);
    do_wb(4'd1, 32'h11, 1'b1, 32'h2000);
  endtask

  task automatic test_async_reset();
    apply_reset();
    fill_branch_head();
    checks++; if (bus.run_upd !== 1'b1 || bus.alloc_tag !== 4'd6) begin failures++; $display("FAIL arst_setup got=%0h/%0d exp=1/6", bus.run_upd, bus.alloc_tag); end
    #2; rst = 1'b1; bus.q1_tag = 4'd2; #1;
    checks++; if ({bus.run_upd, bus.head, bus.alloc_tag, bus.alloc_ready, bus.commit_wr, bus.q1_ready} !== {1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0})
      begin failures++; $display("FAIL arst_mid_commit got=%0h/%0d/%0d/%0h/%0h/%0h exp=0/1/1/1/0/0", bus.run_upd, bus.head, bus.alloc_tag, bus.alloc_ready, bus.commit_wr, bus.q1_ready); end
    rst = 1'b0; bus.q1_tag = 4'd0;
    fill_branch_head();
    step();
    checks++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h2000) begin failures++; $display("FAIL arst_flush_setup got=%0h/%0h exp=1/2000", bus.flush, bus.flush_pc); end
    #2; rst = 1'b1; #1;
    checks++; if ({bus.flush, bus.alloc_ready, bus.alloc_tag, bus.head} !== {1'b0, 1'b1, 4'd1, 4'd1} || bus.flush_pc !== 32'd0)
      begin failures++; $display("FAIL arst_mid_flush got=%0h/%0h/%0h/%0d/%0d exp=0/0/1/1/1", bus.flush, bus.flush_pc, bus.alloc_ready, bus.alloc_tag, bus.head); end
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_random();
    ment_t       mq[$];
    tag_t        m_next;
    logic        m_flush;
    logic [31:0] m_fpc;
    logic        e_ready, e_run, e_wr, e_q1r, e_q2r;
    tag_t        e_tag, e_head;
    reg_t        e_rd;
    logic [31:0] e_res, e_q1v, e_q2v;
    apply_reset();
    m_next = 4'd1; m_flush = 1'b0; m_fpc = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.rdy              = ($urandom_range(0, 7) != 0);
      bus.alloc_valid      = ($urandom_range(0, 9) < 6);
      bus.alloc_rd_hv      = ($urandom_range(0, 3) != 0);
      bus.alloc_rd         = reg_t'($urandom);
      bus.alloc_is_br      = ($urandom_range(0, 4) == 0);
      bus.alloc_pred_taken = 1'($urandom_range(0, 1));
      bus.wb_valid         = ($urandom_range(0, 9) < 7);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) bus.wb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else bus.wb_tag = tag_t'($urandom_range(0, ROB_SZ));
      bus.wb_value         = $urandom;
      bus.wb_br_taken      = 1'($urandom_range(0, 1));
      bus.wb_redirect_pc   = $urandom;
      bus.q1_tag           = tag_t'($urandom_range(0, ROB_SZ));
      bus.q2_tag           = tag_t'($urandom_range(0, ROB_SZ));
      #1;
      e_ready = (mq.size() < int'(ROB_SZ)) && !m_flush;
      e_tag   = m_next;
      e_run   = bus.rdy && !m_flush && mq.size() > 0 && mq[0].done;
      e_head  = (mq.size() > 0) ? mq[0].tag : m_next;
      e_rd    = e_run ? mq[0].rd : '0;
      e_res   = e_run ? mq[0].val : '0;
      e_wr    = e_run && mq[0].hv;
      e_q1r = 1'b0; e_q1v = '0; e_q2r = 1'b0; e_q2v = '0;
      foreach (mq[i]) begin
        if (mq[i].done && mq[i].tag == bus.q1_tag) begin e_q1r = 1'b1; e_q1v = mq[i].val; end
        if (mq[i].done && mq[i].tag == bus.q2_tag) begin e_q2r = 1'b1; e_q2v = mq[i].val; end
      end
      checks++; if (bus.alloc_ready !== e_ready || bus.alloc_tag !== e_tag) begin failures++; $display("FAIL rnd_alloc cyc=%0d got=%0h/%0d exp=%0h/%0d", cyc, bus.alloc_ready, bus.alloc_tag, e_ready, e_tag); end
      checks++; if (bus.run_upd !== e_run || bus.head !== e_head || bus.commit_wr !== e_wr) begin failures++; $display("FAIL rnd_commit cyc=%0d got=%0h/%0d/%0h exp=%0h/%0d/%0h", cyc, bus.run_upd, bus.head, bus.commit_wr, e_run, e_head, e_wr); end
      checks++; if (bus.commit_rd !== e_rd || bus.res !== e_res) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, bus.commit_rd, bus.res, e_rd, e_res); end
      checks++; if (bus.flush !== m_flush || bus.flush_pc !== m_fpc) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, bus.flush, bus.flush_pc, m_flush, m_fpc); end
      checks++; if (bus.q1_ready !== e_q1r || bus.q1_value !== e_q1v || bus.q2_ready !== e_q2r || bus.q2_value !== e_q2v)
        begin failures++; $display("FAIL rnd_lookup cyc=%0d got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", cyc, bus.q1_ready, bus.q1_value, bus.q2_ready, bus.q2_value, e_q1r, e_q1v, e_q2r, e_q2v); end
      step();
      if (bus.rdy) begin
        if (e_run && mq[0].br && (mq[0].pred != mq[0].tk)) begin
          m_fpc = mq[0].pc; mq.delete(); m_next = 4'd1; m_flush = 1'b1;
        end else begin
          if (bus.wb_valid && !m_flush) begin
            foreach (mq[i]) if (mq[i].tag == bus.wb_tag) begin
              mq[i].done = 1'b1; mq[i].val = bus.wb_value; mq[i].tk = bus.wb_br_taken; mq[i].pc = bus.wb_redirect_pc;
            end
          end
          if (e_run) void'(mq.pop_front());
          if (bus.alloc_valid && e_ready) begin
            mq.push_back('{m_next, bus.alloc_rd_hv, bus.alloc_rd, bus.alloc_is_br, bus.alloc_pred_taken, 1'b0, 32'd0, 1'b0, 32'd0});
            m_next = (m_next == tag_t'(ROB_SZ)) ? tag_t'(1) : m_next + tag_t'(1);
          end
          m_flush = 1'b0;
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_in_order_commit();
    test_full_wrap();
    test_mispredict();
    test_bad_writeback();
    test_rdy_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
